// File: rtl/alpha_gpio_if.sv
// Wishbone slave bus bundle for alpha_gpio.
// The SoC side (master) drives the request; the GPIO block (slave) answers.
interface alpha_gpio_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/alpha_gpio.sv
// alpha_gpio: Wishbone-mapped GPIO block with per-pin output, output-enable,
// synchronised input, and edge-triggered interrupt status/enable.
// Only byte lanes 0 and 1 carry register bits; upper lanes are ignored.
module alpha_gpio #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NIO       = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    alpha_gpio_if.slave     wbs,
    input  logic [NIO-1:0]  io_in,
    output logic [NIO-1:0]  io_out,
    output logic [NIO-1:0]  io_oeb,
    output logic [2:0]      user_irq
);

    localparam logic [7:0] OFF_OUT  = 8'h00;
    localparam logic [7:0] OFF_OEB  = 8'h04;
    localparam logic [7:0] OFF_IN   = 8'h08;
    localparam logic [7:0] OFF_IEN  = 8'h0C;
    localparam logic [7:0] OFF_ISR  = 8'h10;
    localparam logic [7:0] OFF_EDGE = 8'h14;

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t          state_q;
    state_t          state_d;

    logic            req;
    logic            commit;
    logic            wr;
    logic [7:0]      off;
    logic [31:0]     bmask;
    logic [NIO-1:0]  wmask;
    logic [NIO-1:0]  wdat;
    logic [31:0]     rdata_d;
    logic [31:0]     rdata_q;

    logic [NIO-1:0]  out_q;
    logic [NIO-1:0]  oeb_q;
    logic [NIO-1:0]  ien_q;
    logic [NIO-1:0]  isr_q;
    logic [NIO-1:0]  edge_q;
    logic [NIO-1:0]  s1_q;
    logic [NIO-1:0]  s2_q;
    logic [NIO-1:0]  p_q;
    logic [NIO-1:0]  evt;
    logic [NIO-1:0]  isr_clr;
    logic            irq_q;

    // Upper byte lanes and data bits above NIO have no storage behind them.
    logic            unused_bits;
    assign unused_bits = &{1'b0, wbs.wbs_sel_i, wbs.wbs_dat_i};

    assign off   = wbs.wbs_adr_i[7:0];
    assign req   = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                   (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign bmask = {16'h0000, {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
    assign wmask = bmask[NIO-1:0];
    assign wdat  = wbs.wbs_dat_i[NIO-1:0];

    // Bus FSM state register; reset forces IDLE so an in-flight ack drops.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: accept a request only from IDLE, ACK always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs of the FSM: ack in ACK, commit strobe on the IDLE->ACK edge.
    always_comb begin
        wbs.wbs_ack_o = 1'b0;
        commit        = 1'b0;
        case (state_q)
            IDLE:    commit = req;
            ACK:     wbs.wbs_ack_o = 1'b1;
            default: ;
        endcase
    end

    assign wr = commit & wbs.wbs_we_i;

    // Read multiplexer; unmapped offsets and bits above NIO read as zero.
    always_comb begin
        rdata_d = '0;
        case (off)
            OFF_OUT:  rdata_d[NIO-1:0] = out_q;
            OFF_OEB:  rdata_d[NIO-1:0] = oeb_q;
            OFF_IN:   rdata_d[NIO-1:0] = s2_q;
            OFF_IEN:  rdata_d[NIO-1:0] = ien_q;
            OFF_ISR:  rdata_d[NIO-1:0] = isr_q;
            OFF_EDGE: rdata_d[NIO-1:0] = edge_q;
            default:  rdata_d = '0;
        endcase
    end

    // Read data is captured at commit and cleared otherwise, so it is
    // nonzero only during the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                      rdata_q <= '0;
        else if (commit && !wbs.wbs_we_i)  rdata_q <= rdata_d;
        else                               rdata_q <= '0;
    end

    assign wbs.wbs_dat_o = rdata_q;

    // Writable configuration registers, merged under the byte-lane mask.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q  <= '0;
            oeb_q  <= '1;
            ien_q  <= '0;
            edge_q <= '0;
        end else if (wr) begin
            case (off)
                OFF_OUT:  out_q  <= (out_q  & ~wmask) | (wdat & wmask);
                OFF_OEB:  oeb_q  <= (oeb_q  & ~wmask) | (wdat & wmask);
                OFF_IEN:  ien_q  <= (ien_q  & ~wmask) | (wdat & wmask);
                OFF_EDGE: edge_q <= (edge_q & ~wmask) | (wdat & wmask);
                default:  ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous pads plus a history flop
    // used for edge detection.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
            p_q  <= '0;
        end else begin
            s1_q <= io_in;
            s2_q <= s1_q;
            p_q  <= s2_q;
        end
    end

    // Edge events come only from s2/p transitions, so rewriting EDGE while
    // a pin is steady never fakes an event.
    always_comb begin
        evt     = (edge_q & p_q & ~s2_q) | (~edge_q & s2_q & ~p_q);
        isr_clr = '0;
        if (wr && (off == OFF_ISR)) isr_clr = wdat & wmask;
    end

    // Interrupt status: W1C clear first, then OR in new events so a
    // coincident event is never lost; summary irq is one cycle behind.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            isr_q <= '0;
            irq_q <= 1'b0;
        end else begin
            isr_q <= (isr_q & ~isr_clr) | evt;
            irq_q <= |(isr_q & ien_q);
        end
    end

    assign io_out   = out_q;
    assign io_oeb   = oeb_q;
    assign user_irq = {2'b00, irq_q};

endmodule

// File: tb/tb_alpha_gpio.sv
// Directed testbench for alpha_gpio with hand-computed expectations.
module tb_alpha_gpio;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic [2:0]  user_irq;

    int n_chk = 0;
    int n_err = 0;

    alpha_gpio_if bus ();

    alpha_gpio #(.BASE_ADDR(BASE), .NIO(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .user_irq (user_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
    endtask

    task automatic wb_start(input logic [31:0] adr, input logic we,
                            input logic [31:0] d, input logic [3:0] sel);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = d;
    endtask

    task automatic wb_write(input string tag, input logic [7:0] off,
                            input logic [31:0] d, input logic [3:0] sel);
        wb_start(BASE | {24'h0, off}, 1'b1, d, sel);
        tick();
        check({tag, "_ack"}, {31'h0, bus.wbs_ack_o}, 32'h1);
        bus_idle();
        tick();
    endtask

    task automatic wb_read(input string tag, input logic [7:0] off, output logic [31:0] d);
        wb_start(BASE | {24'h0, off}, 1'b0, 32'h0, 4'hF);
        tick();
        check({tag, "_ack"}, {31'h0, bus.wbs_ack_o}, 32'h1);
        d = bus.wbs_dat_o;
        bus_idle();
        tick();
        check({tag, "_dat_idle"}, bus.wbs_dat_o, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [5:0]  pat;
        int          acks;

        rst   = 1'b1;
        io_in = 16'h0000;
        bus_idle();
        tick();
        tick();
        check("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        check("rst_dat", bus.wbs_dat_o, 32'h0);
        check("rst_out", {16'h0, io_out}, 32'h0);
        check("rst_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        check("rst_irq", {29'h0, user_irq}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic write/read of OUT with exact ack timing.
        wb_start(BASE | 32'h00, 1'b1, 32'h0000_A5C3, 4'b0011);
        check("out_ack_pre", {31'h0, bus.wbs_ack_o}, 32'h0);
        tick();
        check("out_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
        bus_idle();
        tick();
        check("out_ack_drop", {31'h0, bus.wbs_ack_o}, 32'h0);
        check("io_out", {16'h0, io_out}, 32'h0000_A5C3);
        wb_read("rd_out", 8'h00, rd);
        check("rd_out", rd, 32'h0000_A5C3);

        // Byte-lane masking on OEB; upper lanes have no effect on OUT.
        wb_write("wr_oeb", 8'h04, 32'h0000_1234, 4'b0010);
        check("io_oeb", {16'h0, io_oeb}, 32'h0000_12FF);
        wb_read("rd_oeb", 8'h04, rd);
        check("rd_oeb", rd, 32'h0000_12FF);
        wb_write("wr_hi", 8'h00, 32'hFFFF_0000, 4'b1100);
        check("out_hi_ignored", {16'h0, io_out}, 32'h0000_A5C3);

        // Rising edge on pin 0 with IEN[0]: ISR at N+3, irq at N+4.
        wb_write("wr_ien", 8'h0C, 32'h0000_0001, 4'b0011);
        tick();
        io_in = 16'h0001;
        tick();
        tick();
        tick();
        check("irq_n3", {29'h0, user_irq}, 32'h0);
        tick();
        check("irq_n4", {29'h0, user_irq}, 32'h1);
        wb_read("rd_isr1", 8'h10, rd);
        check("rd_isr1", rd, 32'h1);
        wb_read("rd_in", 8'h08, rd);
        check("rd_in", rd, 32'h1);
        wb_start(BASE | 32'h10, 1'b1, 32'h1, 4'b0011);
        tick();
        check("w1c_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
        check("irq_in_ack", {29'h0, user_irq}, 32'h1);
        bus_idle();
        tick();
        check("irq_cleared", {29'h0, user_irq}, 32'h0);

        // Status sets regardless of IEN; W1C respects byte lanes.
        io_in = 16'h0003;
        repeat (4) tick();
        wb_read("rd_isr2", 8'h10, rd);
        check("rd_isr2", rd, 32'h2);
        check("irq_masked", {29'h0, user_irq}, 32'h0);
        wb_write("w1c_wrong_lane", 8'h10, 32'h2, 4'b0010);
        wb_read("rd_isr_kept", 8'h10, rd);
        check("rd_isr_kept", rd, 32'h2);
        wb_write("w1c_2", 8'h10, 32'h2, 4'b0001);
        wb_read("rd_isr_clr", 8'h10, rd);
        check("rd_isr_clr", rd, 32'h0);

        // Switching pin 1 to falling-edge mode must not create an event.
        wb_write("wr_edge", 8'h14, 32'h2, 4'b0001);
        repeat (3) tick();
        wb_read("rd_isr_edgechg", 8'h10, rd);
        check("rd_isr_edgechg", rd, 32'h0);
        io_in = 16'h0001;
        repeat (4) tick();
        wb_read("rd_isr_fall", 8'h10, rd);
        check("rd_isr_fall", rd, 32'h2);
        wb_write("w1c_fall", 8'h10, 32'h2, 4'b0001);

        // Falling pin 0 in rising mode: no event.
        io_in = 16'h0000;
        repeat (4) tick();
        wb_read("rd_isr_nofall", 8'h10, rd);
        check("rd_isr_nofall", rd, 32'h0);

        // Event and W1C on the same edge: set wins.
        io_in = 16'h0001;
        tick();
        tick();
        wb_start(BASE | 32'h10, 1'b1, 32'h1, 4'b0011);
        tick();
        check("race_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
        bus_idle();
        tick();
        wb_read("rd_isr_race", 8'h10, rd);
        check("rd_isr_race", rd, 32'h1);

        // Writes to IN and unmapped offsets are acked and harmless.
        wb_write("wr_in", 8'h08, 32'h0000_FFFF, 4'b0011);
        wb_read("rd_in2", 8'h08, rd);
        check("rd_in2", rd, 32'h1);
        wb_write("wr_unmapped", 8'h40, 32'h0000_FFFF, 4'b0011);
        wb_read("rd_unmapped", 8'h40, rd);
        check("rd_unmapped", rd, 32'h0);
        check("out_after_unmapped", {16'h0, io_out}, 32'h0000_A5C3);

        // Request held for 6 cycles: acks on alternating cycles.
        acks = 0;
        pat  = '0;
        wb_start(BASE | 32'h00, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            tick();
            pat[i] = bus.wbs_ack_o;
            if (bus.wbs_ack_o) begin
                acks++;
                check("burst_dat", bus.wbs_dat_o, 32'h0000_A5C3);
            end
        end
        bus_idle();
        tick();
        check("burst_acks", acks, 32'd3);
        check("burst_pat", {26'h0, pat}, 32'h15);

        // Out-of-range address: never acked.
        acks = 0;
        wb_start(BASE + 32'h100, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.wbs_ack_o) acks++;
        end
        bus_idle();
        tick();
        check("oor_acks", acks, 32'd0);

        // Reset during ACK overrides the write just committed; pin 0 held high.
        wb_start(BASE | 32'h00, 1'b1, 32'h0000_5A5A, 4'b0011);
        tick();
        check("pre_rst_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
        check("pre_rst_out", {16'h0, io_out}, 32'h0000_5A5A);
        rst = 1'b1;
        bus_idle();
        tick();
        check("rst2_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        check("rst2_out", {16'h0, io_out}, 32'h0);
        check("rst2_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        check("rst2_irq", {29'h0, user_irq}, 32'h0);
        rst = 1'b0;
        wb_read("rd_ien_rst", 8'h0C, rd);
        check("rd_ien_rst", rd, 32'h0);
        wb_read("rd_edge_rst", 8'h14, rd);
        check("rd_edge_rst", rd, 32'h0);
        wb_read("rd_isr_post", 8'h10, rd);
        check("rd_isr_post", rd, 32'h1);
        check("irq_post", {29'h0, user_irq}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
